// File: rtl/weight_loader_3_pkg.sv
// weight_loader_3_pkg: default layer-3 sizes and the loader FSM encoding shared by the layer loaders
package weight_loader_3_pkg;
  localparam int COEFF_WIDTH_DEF = 16;
  localparam int KERN_S_3 = 72;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2} state_t;
endpackage

// File: rtl/weight_loader_3_coeff_ram.sv
// coeff_ram: simple dual-port coefficient RAM, one write port and one registered read-first read port
module coeff_ram #(
  parameter int mem_size = 72,
  parameter int data_width = 16,
  parameter int addr_w = $clog2(mem_size)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [addr_w-1:0]     i_waddr,
  input  logic [data_width-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [addr_w-1:0]     i_raddr,
  output logic [data_width-1:0] o_rdata
);
  localparam logic [addr_w:0] SIZE = (addr_w + 1)'(mem_size);
  logic [data_width-1:0] r_mem [mem_size];
  logic                  w_in_range;
  assign w_in_range = {1'b0, i_raddr} < SIZE;
  // storage write; no reset so the array maps onto block RAM
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // registered read: old content on a same-address write, zero beyond the kernel, holds when idle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_rdata <= '0;
    else if (i_re) o_rdata <= w_in_range ? r_mem[i_raddr] : '0;
endmodule

// File: rtl/weight_loader_3.sv
// weight_loader_3: drains one kernel of coefficients from the stream into RAM and serves reads;
// optional running checksum of popped coefficients when WEIGHT_LOADER_CHECKSUM_EN is defined
module weight_loader_3
  import weight_loader_3_pkg::*;
#(
  parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
  parameter int KERN_SIZE = KERN_S_3,
  parameter int ADDR_W = $clog2(KERN_SIZE)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   start,
  input  logic [COEFF_WIDTH-1:0] input_V_dout,
  input  logic                   input_V_empty_n,
  output logic                   input_V_read,
  output logic                   weights_ready,
  output logic                   load_done,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [COEFF_WIDTH-1:0] rd_data
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [COEFF_WIDTH+ADDR_W-1:0] checksum
`endif
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_wcnt;
  logic              r_load_done, w_enter, w_last;
  assign w_enter = r_state != LOAD && start;
  assign w_last = input_V_read && r_wcnt == ADDR_W'(KERN_SIZE - 1);
  assign load_done = r_load_done;
  // state register
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state: start (re)loads from IDLE or READY, the last pop finishes the load
  always_comb w_next = w_enter ? LOAD : w_last ? READY : r_state;
  // outputs decoded from state; popping is only ever possible while loading
  always_comb begin
    input_V_read = r_state == LOAD && input_V_empty_n;
    weights_ready = r_state == READY;
  end
  // write index: restarts on each load, wraps after the final coefficient, holds on stalls
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) r_wcnt <= '0;
    else if (w_enter || w_last) r_wcnt <= '0;
    else if (input_V_read) r_wcnt <= r_wcnt + 1'b1;
  // completion pulse lands alongside the switch to READY
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) r_load_done <= 1'b0;
    else r_load_done <= w_last;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [COEFF_WIDTH+ADDR_W-1:0] r_sum;
  assign checksum = r_sum;
  // wrapping signed sum of every popped coefficient in the current load
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) r_sum <= '0;
    else if (w_enter) r_sum <= '0;
    else if (input_V_read) r_sum <= r_sum + {{ADDR_W{input_V_dout[COEFF_WIDTH-1]}}, input_V_dout};
`endif
  coeff_ram #(
    .mem_size(KERN_SIZE),
    .data_width(COEFF_WIDTH),
    .addr_w(ADDR_W)
  ) u_ram (
    .i_clk(ap_clk),
    .i_rst_n(ap_rst_n),
    .i_we(input_V_read),
    .i_waddr(r_wcnt),
    .i_wdata(input_V_dout),
    .i_re(rd_en),
    .i_raddr(rd_addr),
    .o_rdata(rd_data)
  );
endmodule

// File: tb/tb_weight_loader_3.sv
// tb_weight_loader_3: directed kernel loads checked every cycle against a queue-level model plus literal expectations
module tb_weight_loader_3;
  localparam int K = 72;
  logic        ap_clk = 0, ap_rst_n = 0, start = 0, input_V_empty_n = 0, rd_en = 0;
  logic [15:0] input_V_dout = 0;
  logic [6:0]  rd_addr = 0;
  logic        input_V_read, weights_ready, load_done;
  logic [15:0] rd_data;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [22:0] checksum;
`endif
  int checks = 0, failures = 0;
  int n_reads = 0, n_done = 0, t_load = 0;

  always #5 ap_clk = ~ap_clk;

  weight_loader_3 dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .start(start),
    .input_V_dout(input_V_dout),
    .input_V_empty_n(input_V_empty_n),
    .input_V_read(input_V_read),
    .weights_ready(weights_ready),
    .load_done(load_done),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // model: a kernel is the list of words accepted since the last honoured start
  bit          m_loading = 0, m_ready = 0, m_done = 0;
  int          m_n = 0;
  logic [15:0] m_mem [K];
  logic [15:0] m_rd = 0;
  logic [22:0] m_sum = 0;

  task automatic model_step();
    if (!ap_rst_n) begin
      m_loading = 0; m_ready = 0; m_done = 0; m_n = 0; m_rd = 0; m_sum = 0;
    end else begin
      m_done = 0;
      if (rd_en) m_rd = (int'(rd_addr) < K) ? m_mem[rd_addr] : 16'd0;
      if (m_loading && input_V_empty_n) begin
        m_mem[m_n] = input_V_dout;
        m_sum = m_sum + 23'(signed'(input_V_dout));
        m_n++;
        if (m_n == K) begin
          m_loading = 0; m_ready = 1; m_done = 1; m_n = 0;
        end
      end else if (start && !m_loading) begin
        m_loading = 1; m_ready = 0; m_n = 0; m_sum = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge ap_clk or negedge ap_rst_n);
    model_step();
  end

  initial forever begin
    @(negedge ap_clk);
    if (input_V_read) n_reads++;
    if (load_done) n_done++;
    chk("input_V_read", input_V_read, m_loading && input_V_empty_n);
    chk("weights_ready", weights_ready, m_ready);
    chk("load_done", load_done, m_done);
    if (m_ready) chk("rd_data", rd_data, m_rd);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("checksum", checksum, m_sum);
`endif
  end

  task automatic cyc();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic load(input logic [15:0] base, input logic [15:0] step, input bit toggle,
                      input bit spam, input int nw);
    int idx = 0;
    start = 1;
    cyc();
    start = 0;
    chk("ready_drop", weights_ready, 0);
    t_load = 0; n_reads = 0; n_done = 0;
    while (idx < nw && t_load < 400) begin
      input_V_empty_n = toggle ? t_load[0] : 1'b1;
      input_V_dout = base + 16'(idx) * step;
      start = spam && (t_load == 10 || t_load == 11);
      #1;
      if (input_V_read) idx++;
      @(posedge ap_clk);
      #2;
      t_load++;
    end
    input_V_empty_n = 0;
    start = 0;
    chk("words_accepted", idx, nw);
  endtask

  task automatic full_load(input string tag, input logic [15:0] base, input logic [15:0] step,
                           input bit toggle, input bit spam, input int cycles);
    load(base, step, toggle, spam, K);
    chk({tag, "_load_cycles"}, t_load, cycles);
    chk({tag, "_done_now"}, load_done, 1);
    chk({tag, "_ready_now"}, weights_ready, 1);
    cyc();
    chk({tag, "_done_cleared"}, load_done, 0);
    cyc();
    chk({tag, "_pops"}, n_reads, K);
    chk({tag, "_done_pulses"}, n_done, 1);
  endtask

  task automatic rd(input string name, input logic [6:0] addr, input logic [15:0] exp);
    rd_en = 1;
    rd_addr = addr;
    cyc();
    chk(name, rd_data, exp);
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_ready", weights_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_read", input_V_read, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    ap_rst_n = 1;
    cyc();

    full_load("ramp", 16'd1, 16'd1, 0, 0, K);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("ramp_checksum", checksum, 23'd2628);
`endif
    rd("rd_0", 7'd0, 16'd1);
    rd("rd_71", 7'd71, 16'd72);
    rd("rd_35", 7'd35, 16'd36);
    rd("rd_80", 7'd80, 16'd0);
    rd_en = 0;
    cyc();
    chk("rd_hold", rd_data, 0);

    full_load("stall", 16'd1, 16'd1, 1, 0, 2 * K);
    rd("stall_rd_0", 7'd0, 16'd1);
    rd("stall_rd_71", 7'd71, 16'd72);
    rd_en = 0;

    full_load("reload", 16'd100, 16'd1, 0, 1, K);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("reload_checksum", checksum, 23'd9756);
`endif
    rd("reload_rd_0", 7'd0, 16'd100);
    rd("reload_rd_71", 7'd71, 16'd171);
    rd_en = 0;

    load(16'd500, 16'd1, 0, 0, 30);
    input_V_empty_n = 1;
    #1;
    chk("pre_rst_read", input_V_read, 1);
    ap_rst_n = 0;
    #1;
    chk("arst_read", input_V_read, 0);
    chk("arst_ready", weights_ready, 0);
    chk("arst_done", load_done, 0);
    chk("arst_rd_data", rd_data, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("arst_checksum", checksum, 0);
`endif
    input_V_empty_n = 0;
    cyc();
    ap_rst_n = 1;
    cyc();
    full_load("after_rst", 16'd200, 16'd1, 0, 0, K);
    rd("after_rst_rd_0", 7'd0, 16'd200);
    rd("after_rst_rd_29", 7'd29, 16'd229);
    rd("after_rst_rd_71", 7'd71, 16'd271);
    rd_en = 0;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    full_load("neg", 16'h8000, 16'd0, 0, 0, K);
    chk("neg_checksum", checksum, 23'(-2359296));
`endif
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
